// File: rtl/video_pkg.sv
// Shared coordinate type, default 640x480 timing constants and the sync bundle type
// used by video_frame_counter and video_sync_dly.
package video_pkg;

  localparam int unsigned CoordW   = 11;
  localparam int unsigned CoordMax = 2047;

  typedef logic [CoordW-1:0] coord_t;

  // 640x480 @ 60 Hz, pixel/line units
  localparam int unsigned HActive = 640;
  localparam int unsigned HFront  = 16;
  localparam int unsigned HSyncW  = 96;
  localparam int unsigned HBack   = 48;
  localparam int unsigned VActive = 480;
  localparam int unsigned VFront  = 10;
  localparam int unsigned VSyncW  = 2;
  localparam int unsigned VBack   = 33;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Syncs are active-low, so the idle bundle is both syncs high with video off.
  localparam sync_t SyncIdle = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

  function automatic int unsigned total_span(input int unsigned active, input int unsigned fp,
                                             input int unsigned sw, input int unsigned bp);
    return active + fp + sw + bp;
  endfunction

endpackage

// File: rtl/video_sync_dly.sv
// Fixed-depth shift register with asynchronous reset to a parameterised value; a depth
// of zero degenerates to a wire.
module video_sync_dly #(
  parameter int unsigned           Width    = 3,
  parameter int unsigned           Depth    = 1,
  parameter logic [Width-1:0]      ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  if (Depth == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign dout = din;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];

    // Shifts every clock, independent of any pixel enable.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < Depth; i++) begin
          stage_q[i] <= ResetVal;
        end
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign dout = stage_q[Depth-1];
  end

endmodule

// File: rtl/video_frame_counter.sv
// Raster h/v counters with frame/line decodes. Defining VIDEO_FC_SYNC_EN adds the
// hsync/vsync/video_on outputs delayed by SYNC_DLY clocks through video_sync_dly.
module video_frame_counter
  import video_pkg::*;
#(
  parameter int unsigned HMAX     = HActive,
  parameter int unsigned VMAX     = VActive,
  parameter int unsigned HFP      = HFront,
  parameter int unsigned HSW      = HSyncW,
  parameter int unsigned HBP      = HBack,
  parameter int unsigned VFP      = VFront,
  parameter int unsigned VSW      = VSyncW,
  parameter int unsigned VBP      = VBack,
  parameter int unsigned SYNC_DLY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        sync_clr,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_end
`ifdef VIDEO_FC_SYNC_EN
  ,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on
`endif
);

  localparam int unsigned HT = total_span(HMAX, HFP, HSW, HBP);
  localparam int unsigned VT = total_span(VMAX, VFP, VSW, VBP);

  localparam coord_t HLast = coord_t'(HT - 1);
  localparam coord_t VLast = coord_t'(VT - 1);

  if (HT > CoordMax || VT > CoordMax) begin : g_span_check
    $error("video_frame_counter: HT/VT exceed 11-bit coordinate range");
  end

  if (SYNC_DLY > 3) begin : g_dly_check
    $error("video_frame_counter: SYNC_DLY must be 0..3");
  end

  coord_t hcount_q, hcount_d;
  coord_t vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (sync_clr) begin
      hcount_d = '0;
      vcount_d = '0;
    end else if (inc) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_end    = (hcount_q == HLast);
  assign frame_start = (hcount_q == '0) && (vcount_q == '0);
  assign frame_end   = (hcount_q == HLast) && (vcount_q == VLast);

`ifdef VIDEO_FC_SYNC_EN
  localparam coord_t HActEnd = coord_t'(HMAX);
  localparam coord_t VActEnd = coord_t'(VMAX);
  localparam coord_t HsStart = coord_t'(HMAX + HFP);
  localparam coord_t HsEnd   = coord_t'(HMAX + HFP + HSW);
  localparam coord_t VsStart = coord_t'(VMAX + VFP);
  localparam coord_t VsEnd   = coord_t'(VMAX + VFP + VSW);

  sync_t sync_raw;
  sync_t sync_dly;

  always_comb begin
    sync_raw          = SyncIdle;
    sync_raw.hsync    = ~((hcount_q >= HsStart) && (hcount_q < HsEnd));
    sync_raw.vsync    = ~((vcount_q >= VsStart) && (vcount_q < VsEnd));
    sync_raw.video_on = (hcount_q < HActEnd) && (vcount_q < VActEnd);
  end

  video_sync_dly #(
    .Width    ($bits(sync_t)),
    .Depth    (SYNC_DLY),
    .ResetVal (SyncIdle)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (sync_raw),
    .dout  (sync_dly)
  );

  assign hsync    = sync_dly.hsync;
  assign vsync    = sync_dly.vsync;
  assign video_on = sync_dly.video_on;
`endif

endmodule

// File: tb/tb_video_frame_counter.sv
// Directed bench for video_frame_counter: default horizontal timing, shortened vertical
// timing (VT=27) so a full frame stays short; sync outputs checked when VIDEO_FC_SYNC_EN is set.
module tb_video_frame_counter;

  localparam int unsigned HT   = 800;
  localparam int unsigned VMX  = 20;
  localparam int unsigned VT   = 27;

  logic        clk = 1'b0;
  logic        reset;
  logic        inc;
  logic        sync_clr;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        frame_start;
  logic        frame_end;
  logic        line_end;
`ifdef VIDEO_FC_SYNC_EN
  logic        hsync;
  logic        vsync;
  logic        video_on;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int   mh;
  int   mv;
  logic ehs;
  logic evs;
  logic evo;

  always #5 clk = ~clk;

  video_frame_counter #(
    .HMAX     (640),
    .VMAX     (VMX),
    .HFP      (16),
    .HSW      (96),
    .HBP      (48),
    .VFP      (2),
    .VSW      (2),
    .VBP      (3),
    .SYNC_DLY (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inc         (inc),
    .sync_clr    (sync_clr),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_end    (line_end)
`ifdef VIDEO_FC_SYNC_EN
    ,
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic raw_hs(input int h);
    return !(h >= 656 && h < 752);
  endfunction

  function automatic logic raw_vs(input int v);
    return !(v >= 22 && v < 24);
  endfunction

  function automatic logic raw_vo(input int h, input int v);
    return (h < 640) && (v < VMX);
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_h"}, 32'(hcount), 32'(mh));
    check({tag, "_v"}, 32'(vcount), 32'(mv));
    check({tag, "_fs"}, 32'(frame_start), 32'(mh == 0 && mv == 0));
    check({tag, "_fe"}, 32'(frame_end), 32'(mh == HT - 1 && mv == VT - 1));
    check({tag, "_le"}, 32'(line_end), 32'(mh == HT - 1));
`ifdef VIDEO_FC_SYNC_EN
    check({tag, "_hs"}, 32'(hsync), 32'(ehs));
    check({tag, "_vs"}, 32'(vsync), 32'(evs));
    check({tag, "_vo"}, 32'(video_on), 32'(evo));
`endif
  endtask

  // One clock with inputs held; model advances and the 1-deep sync model captures.
  task automatic tick();
    logic hs;
    logic vs;
    logic vo;
    hs = raw_hs(mh);
    vs = raw_vs(mv);
    vo = raw_vo(mh, mv);
    @(posedge clk);
    if (sync_clr) begin
      mh = 0;
      mv = 0;
    end else if (inc) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    ehs = hs;
    evs = vs;
    evo = vo;
    #1;
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while ((mh != h || mv != v) && n < HT * VT) begin
      tick();
      n++;
    end
    check("run_to_h", 32'(hcount), 32'(h));
    check("run_to_v", 32'(vcount), 32'(v));
  endtask

  initial begin
    int n_le;
    int n_fe;
    int n_fs;
    reset    = 1'b1;
    inc      = 1'b0;
    sync_clr = 1'b0;
    mh  = 0;
    mv  = 0;
    ehs = 1'b1;
    evs = 1'b1;
    evo = 1'b0;

    #2;
    check_all("rst");
    @(posedge clk);
    #1;
    check_all("rst_edge");
    reset = 1'b0;
    inc   = 1'b1;

    // One full line from reset
    n_le = 0;
    for (int i = 0; i < HT; i++) begin
      check_all("line");
      if (line_end) n_le++;
      tick();
    end
    check_all("line_wrap");
    check("line_end_count", 32'(n_le), 32'd1);

    // Alternate inc near the hsync edge: counts step every 2 clocks, syncs every clock
    run_to(650, 1);
    for (int k = 0; k < 40; k++) begin
      inc = (k % 2 == 0);
      tick();
      check_all("toggle");
    end
    inc = 1'b1;

    // Synchronous clear has priority over inc, and also works with inc low
    run_to(300, 10);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    check_all("clr_inc");
    for (int k = 0; k < 5; k++) tick();
    inc      = 1'b0;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    inc      = 1'b1;
    check_all("clr_noinc");

    // Full frame from (0,0)
    n_fe = 0;
    n_fs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      check_all("frame");
      if (frame_start) n_fs++;
      if (frame_end) begin
        n_fe++;
        check("fe_pos_h", 32'(hcount), 32'(HT - 1));
        check("fe_pos_v", 32'(vcount), 32'(VT - 1));
      end
      tick();
    end
    check_all("frame_wrap");
    check("frame_wrap_fs", 32'(frame_start), 32'd1);
    check("frame_end_count", 32'(n_fe), 32'd1);
    check("frame_start_count", 32'(n_fs), 32'd1);

    // Asynchronous reset mid-line, mid-clock
    for (int k = 0; k < 5; k++) tick();
    check_all("pre_arst");
    #3;
    reset = 1'b1;
    #1;
    mh  = 0;
    mv  = 0;
    ehs = 1'b1;
    evs = 1'b1;
    evo = 1'b0;
    check_all("arst");
    @(posedge clk);
    #1;
    check_all("arst_hold");
    #3;
    reset = 1'b0;
    tick();
    check_all("arst_rel");
    check("arst_rel_h1", 32'(hcount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
